// File: rtl/capture_trigger.sv
// Registers ADC samples into a valid/data stream and emits a one-shot threshold trigger
// with holdoff. Optional feature macro: CAPTURE_TRIGGER_HYSTERESIS_EN (hysteresis on "pre").
module capture_trigger #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int HYST              = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic [SAMPLE_DATA_WIDTH-1:0] threshold,
  input  logic                         edge_sel,
  input  logic                         arm,
  input  logic                         auto_rearm,
  input  logic                         force_trig,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         trigger,
  output logic [1:0]                   state
);

  localparam int W       = SAMPLE_DATA_WIDTH;
  localparam int CNT_W   = $clog2(CAPTURE_LENGTH + 1);
  localparam int MAX_VAL = (1 << W) - 1;

`ifdef CAPTURE_TRIGGER_HYSTERESIS_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam int HYST_EFF = HYST_ON ? ((HYST > MAX_VAL) ? MAX_VAL : HYST) : 0;
  localparam logic [W-1:0]   HYST_W   = W'(HYST_EFF);
  localparam logic [W:0]     HYST_EXT = (W+1)'(HYST_EFF);
  localparam logic [W:0]     MAX_EXT  = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0]   MAX_W    = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAPTURE_LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_READY   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               force_q, force_d;
  logic               axiov_q, axiov_d;
  logic [W-1:0]       axiod_q, axiod_d;
  logic               trigger_q, trigger_d;

  logic [W-1:0]       pre_lo_s;
  logic [W-1:0]       pre_hi_s;
  logic [W:0]         pre_hi_ext_s;
  logic               pre_s;
  logic               cross_s;
  logic               force_eff_s;
  logic               fire_s;
  state_e             rearm_s;

  // Saturated pre levels and the pre/cross conditions for the current sample
  always_comb begin
    if (threshold >= HYST_W) begin
      pre_lo_s = threshold - HYST_W;
    end else begin
      pre_lo_s = '0;
    end
    pre_hi_ext_s = {1'b0, threshold} + HYST_EXT;
    if (pre_hi_ext_s > MAX_EXT) begin
      pre_hi_s = MAX_W;
    end else begin
      pre_hi_s = pre_hi_ext_s[W-1:0];
    end
    if (edge_sel) begin
      pre_s   = (axiid > pre_hi_s);
      cross_s = (axiid <= threshold);
    end else begin
      pre_s   = (axiid < pre_lo_s);
      cross_s = (axiid >= threshold);
    end
  end

  // Next-state logic for the datapath register and the trigger FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    force_d     = force_q;
    axiov_d     = axiiv;
    axiod_d     = axiiv ? axiid : axiod_q;
    trigger_d   = 1'b0;
    force_eff_s = force_q | force_trig;
    rearm_s     = auto_rearm ? ST_ARMED : ST_IDLE;
    fire_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        force_d = 1'b0;
        cnt_d   = '0;
        if (arm) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED, ST_READY: begin
        // A pending or same-cycle force rides on the next valid sample
        fire_s = axiiv & (force_eff_s | ((state_q == ST_READY) & cross_s));
        if (fire_s) begin
          trigger_d = 1'b1;
          force_d   = 1'b0;
          if (CAPTURE_LENGTH <= 1) begin
            state_d = rearm_s;
            cnt_d   = '0;
          end else begin
            state_d = ST_HOLDOFF;
            cnt_d   = CNT_ONE;
          end
        end else begin
          force_d = force_eff_s;
          if (axiiv && pre_s) begin
            state_d = ST_READY;
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_HOLDOFF: begin
        force_d = 1'b0;
        if (axiiv) begin
          if (cnt_q >= CNT_LAST) begin
            state_d = rearm_s;
            cnt_d   = '0;
          end else begin
            state_d = ST_HOLDOFF;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        force_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      force_q   <= 1'b0;
      axiov_q   <= 1'b0;
      axiod_q   <= '0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      force_q   <= force_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      trigger_q <= trigger_d;
    end
  end

  assign axiov   = axiov_q;
  assign axiod   = axiod_q;
  assign trigger = trigger_q;
  assign state   = state_q;

endmodule

// File: tb/tb_capture_trigger.sv
// Scoreboard bench for capture_trigger (CAPTURE_LENGTH=8): directed samples push expected
// {data,trigger} pairs; a negedge monitor pops and compares each output sample.
module tb_capture_trigger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       axiiv;
  logic [7:0] axiid;
  logic [7:0] threshold;
  logic       edge_sel;
  logic       arm;
  logic       auto_rearm;
  logic       force_trig;
  logic       axiov;
  logic [7:0] axiod;
  logic       trigger;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  capture_trigger #(
    .SAMPLE_DATA_WIDTH(8),
    .CAPTURE_LENGTH(8),
    .HYST(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .threshold(threshold),
    .edge_sel(edge_sel), .arm(arm), .auto_rearm(auto_rearm), .force_trig(force_trig),
    .axiov(axiov), .axiod(axiod), .trigger(trigger), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output sample must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (axiov === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: axiod=%0d trigger=%0d, expected no sample", axiod, trigger);
        end else begin
          mon_e = exp_q.pop_front();
          chk("axiod", {24'd0, axiod}, {24'd0, mon_e[8:1]});
          chk("trigger", {31'd0, trigger}, {31'd0, mon_e[0]});
        end
      end else if (trigger !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL trigger_without_valid: got %0d, expected 0", trigger);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic t,
                      input logic a, input logic f);
    @(negedge clk);
    axiiv = v; axiid = d; arm = a; force_trig = f;
    if (v) exp_q.push_back({d, t});
    @(negedge clk);
    axiiv = 1'b0; arm = 1'b0; force_trig = 1'b0;
  endtask

  task automatic samp(input logic [7:0] d, input logic t);
    step(1'b1, d, t, 1'b0, 1'b0);
  endtask

  task automatic do_arm();
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic st(input string name, input logic [1:0] exp);
    chk(name, {30'd0, state}, {30'd0, exp});
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) samp(8'd77, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; axiiv = 1'b0; axiid = 8'd0; threshold = 8'd100; edge_sel = 1'b0;
    arm = 1'b0; auto_rearm = 1'b0; force_trig = 1'b0;

    // reset while samples arrive
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); axiiv = 1'b1; axiid = 8'hA5;
      @(negedge clk);
      chk("rst_axiov", {31'd0, axiov}, 32'd0);
      chk("rst_axiod", {24'd0, axiod}, 32'd0);
      chk("rst_trigger", {31'd0, trigger}, 32'd0);
      st("rst_state", 2'd0);
      axiiv = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1;

    // rising crossing, auto_rearm=0
    do_arm();                st("rise_armed", 2'd1);
    samp(8'd50, 1'b0);       st("rise_ready", 2'd2);
    samp(8'd90, 1'b0); samp(8'd99, 1'b0); st("rise_ready_pre", 2'd2);
    samp(8'd100, 1'b1);      st("rise_holdoff", 2'd3);
    samp(8'd120, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1); st("holdoff_ignores_arm_force", 2'd3);
    samp(8'd130, 1'b0); samp(8'd140, 1'b0); samp(8'd150, 1'b0);
    samp(8'd160, 1'b0); samp(8'd170, 1'b0); st("holdoff_post6", 2'd3);
    samp(8'd180, 1'b0);      st("holdoff_to_idle", 2'd0);
    samp(8'd50, 1'b0); samp(8'd150, 1'b0); st("idle_no_trig", 2'd0);

    // auto_rearm=1
    auto_rearm = 1'b1;
    do_arm(); samp(8'd50, 1'b0); samp(8'd100, 1'b1); st("auto_holdoff", 2'd3);
    fill(6);                 st("auto_post6", 2'd3);
    fill(1);                 st("auto_rearmed", 2'd1);
    samp(8'd50, 1'b0); samp(8'd150, 1'b1); st("auto_retrig", 2'd3);
    auto_rearm = 1'b0;
    fill(7);                 st("auto_done", 2'd0);

    // falling edge
    edge_sel = 1'b1; threshold = 8'd60;
    do_arm(); samp(8'd200, 1'b0); samp(8'd61, 1'b0); st("fall_ready", 2'd2);
    samp(8'd60, 1'b1);       st("fall_holdoff", 2'd3);
    fill(7);                 st("fall_done", 2'd0);
    do_arm(); samp(8'd40, 1'b0); samp(8'd30, 1'b0); samp(8'd50, 1'b0);
    st("fall_no_pre", 2'd1);

    // force trigger while armed at a level far below threshold
    edge_sel = 1'b0; threshold = 8'd100;
    samp(8'd10, 1'b0);       st("force_ready", 2'd2);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1); st("force_pending", 2'd2);
    samp(8'd10, 1'b1);       st("force_holdoff", 2'd3);
    fill(7);                 st("force_done", 2'd0);
    do_arm(); samp(8'd10, 1'b0);
    step(1'b1, 8'd100, 1'b1, 1'b0, 1'b1); st("force_cross_holdoff", 2'd3);
    samp(8'd100, 1'b0); fill(6); st("force_cross_done", 2'd0);

    // force in IDLE is not remembered
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    do_arm(); samp(8'd10, 1'b0); st("idle_force_dropped", 2'd2);
    samp(8'd150, 1'b1); samp(8'd77, 1'b0); samp(8'd77, 1'b0);
    st("mid_capture", 2'd3);

    // reset mid-capture
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_axiov", {31'd0, axiov}, 32'd0);
    chk("midrst_axiod", {24'd0, axiod}, 32'd0);
    st("midrst_state", 2'd0);
    @(negedge clk); rst_n = 1'b1;

    // arm with a same-cycle sample: sample not evaluated
    step(1'b1, 8'd50, 1'b0, 1'b1, 1'b0); st("arm_with_sample", 2'd1);
    samp(8'd50, 1'b0); samp(8'd100, 1'b1);
    fill(6);                 st("fresh_count_post6", 2'd3);
    fill(1);                 st("fresh_count_done", 2'd0);

    // threshold change alone does not move the FSM
    do_arm(); samp(8'd50, 1'b0);
    threshold = 8'd40;
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0); st("thr_change_hold", 2'd2);
    samp(8'd45, 1'b1);       st("thr_change_trig", 2'd3);
    fill(7);                 st("thr_change_done", 2'd0);

`ifdef CAPTURE_TRIGGER_HYSTERESIS_EN
    threshold = 8'd100;
    do_arm(); samp(8'd98, 1'b0); samp(8'd101, 1'b0); st("hyst_no_pre", 2'd1);
    samp(8'd95, 1'b0); samp(8'd101, 1'b1); st("hyst_trig", 2'd3);
    fill(7);                 st("hyst_done", 2'd0);
    threshold = 8'd2;
    do_arm(); samp(8'd1, 1'b0); samp(8'd2, 1'b0); st("hyst_sat_low", 2'd1);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
